// File: rtl/parallel_to_serial.sv
`default_nettype none
// ============================================================================
// Module      : parallel_to_serial
// Description : Parallel-in / serial-out shift register with serial MSB fill,
//               shifting LSB first. Operand serialiser for the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_to_serial #(
    parameter int P_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               l_s,
    input  logic [P_WIDTH-1:0] p_in,
    input  logic               s_in,
    output logic               s_out
);

    localparam logic c_MODE_LOAD = 1'b0;

    logic [P_WIDTH-1:0] w_sr_d;
    logic [P_WIDTH-1:0] r_sr_q;

    // Reset takes priority, then load; otherwise a logical right shift with s_in at the MSB.
    always_comb begin
        w_sr_d = r_sr_q;
        if (rst) begin
            w_sr_d = '0;
        end else if (l_s == c_MODE_LOAD) begin
            w_sr_d = p_in;
        end else begin
            w_sr_d = {s_in, r_sr_q[P_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        r_sr_q <= w_sr_d;
    end

    assign s_out = r_sr_q[0];

endmodule
`default_nettype wire

// File: tb/tb_parallel_to_serial.sv
`default_nettype none
// Self-checking bench for parallel_to_serial (P_WIDTH = 8); reference model is a
// bit queue holding the stream that will emerge on s_out, front element first.
module tb_parallel_to_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         l_s;
    logic [W-1:0] p_in;
    logic         s_in;
    logic         s_out;

    int n_cmp = 0;
    int n_err = 0;

    logic mdl[$];

    parallel_to_serial #(.P_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .l_s   (l_s),
        .p_in  (p_in),
        .s_in  (s_in),
        .s_out (s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge, advance the model at the rising edge,
    // and return 1 time unit after it so callers sample settled outputs.
    task automatic drive(input logic r, input logic l, input logic [W-1:0] p, input logic s);
        @(negedge clk);
        rst  = r;
        l_s  = l;
        p_in = p;
        s_in = s;
        @(posedge clk);
        if (r) begin
            mdl.delete();
            for (int i = 0; i < W; i++) mdl.push_back(1'b0);
        end else if (!l) begin
            mdl.delete();
            for (int i = 0; i < W; i++) mdl.push_back(p[i]);
        end else begin
            void'(mdl.pop_front());
            mdl.push_back(s);
        end
        #1;
    endtask

    // Load w, then capture s_out before each of 16 shifts; shift k drives sin[k].
    task automatic run_stream(input logic [W-1:0] w, input logic [2*W-1:0] sin,
                              output logic [2*W-1:0] cap);
        drive(1'b0, 1'b0, w, 1'b0);
        for (int k = 0; k < 2*W; k++) begin
            cap[k] = s_out;
            drive(1'b0, 1'b1, 8'h00, sin[k]);
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 8'hFF, 1'b1);
            n_cmp++;
            if (s_out !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: s_out=%b expected=0", c, s_out);
            end
        end
        drive(1'b0, 1'b0, 8'hFF, 1'b0);
        n_cmp++;
        if (s_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_load: s_out=%b expected=1", s_out);
        end
    endtask

    task automatic test_directed_streams();
        logic [2*W-1:0] cap;
        run_stream(8'h00, 16'h0000, cap);
        n_cmp++;
        if (cap !== 16'h0000) begin
            n_err++;
            $display("FAIL stream_zeros: got=%h expected=0000", cap);
        end
        run_stream(8'hFF, 16'h0000, cap);
        n_cmp++;
        if (cap !== 16'h00FF) begin
            n_err++;
            $display("FAIL stream_ones: got=%h expected=00ff", cap);
        end
        run_stream(8'h00, 16'h00FF, cap);
        n_cmp++;
        if (cap !== 16'hFF00) begin
            n_err++;
            $display("FAIL stream_serial_fill: got=%h expected=ff00", cap);
        end
        run_stream(8'hA5, {8'h5A, 8'h3C}, cap);
        n_cmp++;
        if (cap !== 16'h3CA5) begin
            n_err++;
            $display("FAIL stream_a5_3c: got=%h expected=3ca5", cap);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   p_val;
        logic [W-1:0]   s_val;
        logic [W-1:0]   tail;
        logic [2*W-1:0] cap;
        for (int it = 0; it < 12; it++) begin
            p_val = W'($urandom);
            s_val = W'($urandom);
            tail  = W'($urandom);
            // Held load mode: earlier captures are overwritten, the last word wins.
            for (int h = $urandom_range(0, 2); h > 0; h--) begin
                drive(1'b0, 1'b0, W'($urandom), 1'($urandom));
            end
            drive(1'b0, 1'b0, p_val, 1'($urandom));
            for (int k = 0; k < 2*W; k++) begin
                cap[k] = s_out;
                n_cmp++;
                if (s_out !== mdl[0]) begin
                    n_err++;
                    $display("FAIL random_bit it=%0d k=%0d: s_out=%b model=%b", it, k, s_out, mdl[0]);
                end
                drive(1'b0, 1'b1, W'($urandom), (k < W) ? s_val[k] : tail[k-W]);
            end
            n_cmp++;
            if (cap !== {s_val, p_val}) begin
                n_err++;
                $display("FAIL random_stream it=%0d: got=%h expected=%h", it, cap, {s_val, p_val});
            end
        end
    endtask

    task automatic test_mid_shift();
        logic [2:0] seq;
        logic [W-1:0] cap;
        drive(1'b0, 1'b0, 8'hA5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            seq[k] = s_out;
            drive(1'b0, 1'b1, 8'h00, 1'b1);
        end
        n_cmp++;
        if (seq !== 3'b101) begin
            n_err++;
            $display("FAIL mid_shift_prefix: got=%b expected=101", seq);
        end
        drive(1'b0, 1'b0, 8'h0F, 1'b1);
        for (int k = 0; k < W; k++) begin
            cap[k] = s_out;
            drive(1'b0, 1'b1, 8'hFF, 1'b0);
        end
        n_cmp++;
        if (cap !== 8'h0F) begin
            n_err++;
            $display("FAIL mid_shift_reload: got=%h expected=0f", cap);
        end
        drive(1'b0, 1'b0, 8'hA5, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        n_cmp++;
        if (s_out !== 1'b0) begin
            n_err++;
            $display("FAIL mid_shift_reset: s_out=%b expected=0", s_out);
        end
        // After reset, in-flight bits are gone: shifting zeros must emit zeros only.
        for (int k = 0; k < W; k++) begin
            cap[k] = s_out;
            drive(1'b0, 1'b1, 8'hFF, 1'b0);
        end
        n_cmp++;
        if (cap !== 8'h00) begin
            n_err++;
            $display("FAIL post_reset_drain: got=%h expected=00", cap);
        end
    endtask

    initial begin
        rst  = 1'b1;
        l_s  = 1'b0;
        p_in = '0;
        s_in = 1'b0;
        test_reset();
        test_directed_streams();
        test_random();
        test_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
